// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pll_ctrl_pkg
//  Purpose  : Shared state encoding and sizing helper for the PLL controllers.
//  Revision : 1.0  initial release
// ============================================================================
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pll_state_e;

    // Number of bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
//  Module   : sync_bit
//  Purpose  : Multi-stage flop chain bringing an asynchronous level into clk.
//  Revision : 1.0  initial release
// ============================================================================
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;

    always_comb begin
        w_sync_d = {r_sync_q[SYNC_STAGES-2:0], i_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q <= '0;
        end else begin
            r_sync_q <= w_sync_d;
        end
    end

    assign o_q = r_sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_sequencer
//  Purpose  : Resets one PLL, waits for a stable lock, retries on loss of
//             lock and latches FAULT once the retry budget is spent.
//  Revision : 1.0  initial release
// ============================================================================
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 64,
    parameter int MAX_RETRIES  = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic       CLEAR_FAULT,
    input  logic       PLL_LOCKED,
    output logic       PLL_RST,
    output logic       PLL_PWRDWN,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_COUNT,
    output logic [2:0] STATE
);

    localparam int c_tmax_a = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_tmax   = (c_tmax_a > LOCK_STABLE) ? c_tmax_a : LOCK_STABLE;
    localparam int c_tw     = clog2(c_tmax + 1);

    localparam logic [c_tw-1:0] c_timer_max    = c_tw'(c_tmax);
    localparam logic [c_tw-1:0] c_rst_last     = c_tw'(RST_CYCLES - 1);
    localparam logic [c_tw-1:0] c_timeout_last = c_tw'(LOCK_TIMEOUT - 1);
    localparam logic [c_tw-1:0] c_stable_last  = c_tw'(LOCK_STABLE - 1);
    localparam logic [3:0]      c_max_retries  = 4'(MAX_RETRIES);

    logic            w_lk;
    pll_state_e      r_state_q, w_state_d;
    logic [c_tw-1:0] r_timer_q, w_timer_d;
    logic [3:0]      r_retry_q, w_retry_d, w_retry_inc;
    logic            r_pwrdwn_q, w_pwrdwn_d;
    logic            r_pll_rst_q, w_pll_rst_d;
    logic            r_ready_q, w_ready_d;
    logic            r_fault_q, w_fault_d;
    logic            w_fail;

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (CLK),
        .rst (RST),
        .i_d (PLL_LOCKED),
        .o_q (w_lk)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_retry_d   = r_retry_q;
        w_fail      = 1'b0;
        w_retry_inc = (r_retry_q == 4'hF) ? r_retry_q : r_retry_q + 4'd1;

        if (!ENABLE && (r_state_q != ST_FAULT)) begin
            w_state_d = ST_OFF;
        end else begin
            case (r_state_q)
                ST_OFF: begin
                    w_state_d = ST_RESET;
                end
                ST_RESET: begin
                    if (r_timer_q == c_rst_last) begin
                        w_state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lk) begin
                        w_state_d = ST_STABLE;
                    end else if (r_timer_q == c_timeout_last) begin
                        w_fail = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!w_lk) begin
                        w_fail = 1'b1;
                    end else if (r_timer_q == c_stable_last) begin
                        w_state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!w_lk) begin
                        w_fail = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (CLEAR_FAULT) begin
                        w_retry_d = 4'd0;
                        w_state_d = ENABLE ? ST_RESET : ST_OFF;
                    end
                end
                default: begin
                    w_state_d = ST_OFF;
                end
            endcase

            if (w_fail) begin
                w_retry_d = w_retry_inc;
                w_state_d = (w_retry_inc >= c_max_retries) ? ST_FAULT : ST_RESET;
            end
        end

        if ((w_state_d == ST_RUN) && (r_state_q != ST_RUN)) begin
            w_retry_d = 4'd0;
        end

        // One shared timer: restarts on every state change, saturates otherwise.
        if (w_state_d != r_state_q) begin
            w_timer_d = '0;
        end else if (r_timer_q == c_timer_max) begin
            w_timer_d = r_timer_q;
        end else begin
            w_timer_d = r_timer_q + c_tw'(1);
        end

        // Outputs decoded from the next state so they change with the state.
        w_pwrdwn_d  = 1'b0;
        w_pll_rst_d = 1'b0;
        w_ready_d   = 1'b0;
        w_fault_d   = 1'b0;
        case (w_state_d)
            ST_OFF: begin
                w_pwrdwn_d  = 1'b1;
                w_pll_rst_d = 1'b1;
            end
            ST_RESET:     w_pll_rst_d = 1'b1;
            ST_RUN:       w_ready_d   = 1'b1;
            ST_FAULT: begin
                w_pll_rst_d = 1'b1;
                w_fault_d   = 1'b1;
            end
            default: begin
                w_pll_rst_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q   <= ST_OFF;
            r_timer_q   <= '0;
            r_retry_q   <= 4'd0;
            r_pwrdwn_q  <= 1'b1;
            r_pll_rst_q <= 1'b1;
            r_ready_q   <= 1'b0;
            r_fault_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_timer_q   <= w_timer_d;
            r_retry_q   <= w_retry_d;
            r_pwrdwn_q  <= w_pwrdwn_d;
            r_pll_rst_q <= w_pll_rst_d;
            r_ready_q   <= w_ready_d;
            r_fault_q   <= w_fault_d;
        end
    end

    assign PLL_RST     = r_pll_rst_q;
    assign PLL_PWRDWN  = r_pwrdwn_q;
    assign READY       = r_ready_q;
    assign FAULT       = r_fault_q;
    assign RETRY_COUNT = r_retry_q;
    assign STATE       = r_state_q;

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences one PLL primitive (a PLLE2_BASE-style instance): drives its RST and PWRDWN inputs and supervises its LOCKED output.
- Issues a timed reset pulse, waits for lock with a timeout, and requires lock to stay stable before asserting READY.
- Detects loss of lock and retries up to a bounded count; after that it latches FAULT.
- Sits beside each PLL instance, clocked by a free-running reference clock that does not come from the PLL, and gates downstream resets.

Parameters:
- RST_CYCLES, 16, number of CLK cycles PLL_RST is held high per attempt (≥1).
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before the attempt counts as failed (≥2).
- LOCK_STABLE, 64, consecutive cycles synchronized lock must stay high before READY (≥1).
- MAX_RETRIES, 3, failed attempts tolerated before FAULT (1..15).
- SYNC_STAGES, 2, flip-flop stages in the PLL_LOCKED synchronizer (≥2).

Ports:
- CLK  input  1  free-running reference clock.
- RST  input  1  synchronous, active-high reset.
- ENABLE  input  1  level; 1 = run the PLL, 0 = power the PLL down.
- CLEAR_FAULT  input  1  single-cycle pulse; leaves FAULT and restarts the sequence.
- PLL_LOCKED  input  1  LOCKED from the PLL; asynchronous to CLK.
- PLL_RST  output  1  to PLL RST.
- PLL_PWRDWN  output  1  to PLL PWRDWN.
- READY  output  1  PLL locked and stable; downstream may release resets.
- FAULT  output  1  retries exhausted; sticky.
- RETRY_COUNT  output  4  failed attempts since the last READY or CLEAR_FAULT.
- STATE  output  3  current state encoding, for debug.

Behaviour:
- Reset values (RST=1): state OFF, PLL_PWRDWN=1, PLL_RST=1, READY=0, FAULT=0, RETRY_COUNT=0, synchronizer flops=0, all counters=0.
- PLL_LOCKED enters through the SYNC_STAGES-deep synchronizer; only its output (lk) is used.
- One timer counter is shared by all timed states. It is wide enough for max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE) and clears on every state change.
- States (3-bit encoding): OFF=0, RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
- OFF:
  - PLL_PWRDWN=1, PLL_RST=1.
  - Goes to RESET on ENABLE=1.
- RESET:
  - PLL_PWRDWN=0, PLL_RST=1.
  - After exactly RST_CYCLES cycles in RESET, goes to WAIT_LOCK.
- WAIT_LOCK:
  - PLL_RST=0.
  - lk=1 → STABLE.
  - Timer reaching LOCK_TIMEOUT-1 with lk=0 → fail.
- STABLE:
  - lk=0 → fail.
  - LOCK_STABLE consecutive cycles with lk=1 → RUN.
- RUN:
  - READY=1, registered; it rises the cycle the state becomes RUN.
  - Entering RUN clears RETRY_COUNT.
  - lk=0 → READY=0 next cycle, then fail.
- fail:
  - RETRY_COUNT increments (saturating at 15).
  - If the new count ≥ MAX_RETRIES → FAULT; otherwise → RESET.
- FAULT:
  - PLL_RST=1, PLL_PWRDWN=0, FAULT=1.
  - CLEAR_FAULT → RETRY_COUNT=0, FAULT=0, go to RESET.
- ENABLE=0 in any state except FAULT → OFF next cycle.
  - READY drops on that same edge.
  - RETRY_COUNT is kept.
- ENABLE=0 while in FAULT: stays in FAULT. CLEAR_FAULT with ENABLE=0 → OFF.
- Priority on the same edge: RST > ENABLE=0 > fail/timeout > CLEAR_FAULT > normal advance.
- RST asserted mid-sequence aborts everything, including a reset pulse in progress, and restores the reset values on the next edge.
- READY is never 1 in the same cycle as PLL_RST=1 or FAULT=1.
- Outputs are registered: no combinational path from any input to any output.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - the state enum (3-bit, with the values above);
  - the function clog2 used to size the timer.
- One sub-module, sync_bit: a parameterized SYNC_STAGES flop chain. It is reused by the other controllers for their async status inputs.

Test Plan (use RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=3, SYNC_STAGES=2):
- Normal bring-up: ENABLE=1 at cycle 0, PLL_LOCKED rises at cycle 10 and stays high.
  - PLL_PWRDWN falls at cycle 1.
  - PLL_RST is high for exactly 4 cycles after that, then falls.
  - READY rises 2 (sync) + 8 (stable) cycles after lock is sampled.
  - RETRY_COUNT=0.
- Lock glitch in STABLE: PLL_LOCKED drops for 1 cycle after 5 stable cycles.
  - RETRY_COUNT=1.
  - A new 4-cycle PLL_RST pulse follows.
  - READY only after 8 fresh stable cycles, then RETRY_COUNT=0.
- Never locks: PLL_LOCKED held at 0.
  - Three timeouts of 20 cycles each.
  - Then FAULT=1, RETRY_COUNT=3, PLL_RST=1.
  - A CLEAR_FAULT pulse gives RETRY_COUNT=0 and state RESET.
- Loss of lock in RUN: PLL_LOCKED falls.
  - READY=0 within 3 cycles, RETRY_COUNT=1, relock sequence runs.
- ENABLE=0 in WAIT_LOCK: PLL_PWRDWN=1 and PLL_RST=1 the next cycle, state OFF, READY stays 0.
- RST pulse in the middle of RESET: all outputs return to their reset values on the next edge; the sequence restarts when ENABLE is re-sampled.
